// File: rtl/load_store_unit.sv
// load_store_unit: translates RISC-V load/store requests into aligned word
// accesses with byte enables. Sub-word loads are lane-selected and extended.
// Sub-word stores are lane-replicated. Misaligned or illegal accesses are
// answered with an error response and never reach memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    write_r;
    logic [2:0]              funct3_r;
    logic [1:0]              lane_r;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [3:0]              mem_be_r;
    logic [31:0]             mem_wdata_r;
    logic                    resp_valid_r;
    logic [31:0]             resp_rdata_r;
    logic                    resp_error_r;

    logic                    err_s;
    logic [3:0]              be_s;
    logic [31:0]             wdata_s;
    logic [7:0]              byte_s;
    logic [15:0]             half_s;
    logic [31:0]             load_s;

    // Ready depends on reset directly so it is low for the whole reset cycle.
    assign req_ready  = (state_r == ST_IDLE) && !reset;

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_error = resp_error_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;

    // Classify the incoming request: error, byte enables and replicated store data.
    always_comb begin
        err_s   = 1'b0;
        be_s    = 4'b0000;
        wdata_s = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: be_s = 4'b0001 << req_addr[1:0];
            3'b001, 3'b101: be_s = req_addr[1] ? 4'b1100 : 4'b0011;
            3'b010:         be_s = 4'b1111;
            default:        be_s = 4'b0000;
        endcase
        case (req_funct3[1:0])
            2'b00:   wdata_s = {4{req_wdata[7:0]}};
            2'b01:   wdata_s = {2{req_wdata[15:0]}};
            default: wdata_s = req_wdata;
        endcase
        // 011/110/111 are not loads or stores; unsigned variants exist only for loads.
        if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
            (req_funct3[2] && req_write)) begin
            err_s = 1'b1;
        end else if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            err_s = 1'b1;
        end else if ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        load_s = 32'h0000_0000;
        case (lane_r)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            2'd3:    byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_r[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        if (write_r) begin
            load_s = 32'h0000_0000;
        end else begin
            case (funct3_r)
                3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
                3'b100:  load_s = {24'h00_0000, byte_s};
                3'b001:  load_s = {{16{half_s[15]}}, half_s};
                3'b101:  load_s = {16'h0000, half_s};
                3'b010:  load_s = mem_rdata;
                default: load_s = 32'h0000_0000;
            endcase
        end
    end

    // Control FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            funct3_r     <= 3'b000;
            lane_r       <= 2'b00;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (req_valid) begin
                        write_r  <= req_write;
                        funct3_r <= req_funct3;
                        lane_r   <= req_addr[1:0];
                        if (err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ST_ACCESS;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_write;
                            mem_addr_r  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wdata_s;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        state_r      <= ST_RESP;
                        mem_req_r    <= 1'b0;
                        mem_we_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= 1'b0;
                        resp_rdata_r <= load_s;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_req_r    <= 1'b0;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU execute stage and `data_memory`, translating RISC-V load/store requests into aligned word accesses with byte enables. Handles sub-word data: lane selection for LB/LH/LW/LBU/LHU loads with sign/zero extension, and lane replication for SB/SH/SW stores. Detects misaligned and illegal accesses without touching memory. Uses a valid/ready request handshake on the CPU side and a req/ack handshake with variable-latency memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  CPU presents an access.
- `req_ready`  out  1  LSU can accept; high only in IDLE with `reset` low.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  access was misaligned or illegal; valid only with `resp_valid`.
- `mem_req`  out  1  memory access request; held until ack.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address; `req_addr` with bits [1:0] cleared.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory done; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states:
  - **IDLE**: `req_ready` = 1.
  - **ACCESS**: `mem_req` = 1.
  - **RESP**: `resp_valid` = 1.
- A request is accepted when `req_valid && req_ready`. On acceptance the LSU latches write, funct3, addr and wdata.
- Error check at acceptance:
  - Illegal: funct3 ∈ {011, 110, 111}, or funct3 ∈ {100, 101} with `req_write` = 1.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 00.
  - On error: go directly to RESP with `resp_error` = 1 and `resp_rdata` = 0. `mem_req` is never asserted.
- Otherwise go to ACCESS with `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` registered. These stay stable until the ack.
- Byte enables (`mem_be`), applied to both loads and stores:
  - B/BU: 0001 shifted left by addr[1:0].
  - H/HU: 0011 if addr[1] = 0, else 1100.
  - W: 1111.
- Store data (`mem_wdata`):
  - SB: byte replicated to all four lanes.
  - SH: halfword replicated to both halves.
  - SW: passed through unchanged.
- Load extraction (all from `mem_rdata`):
  - B: lane addr[1:0], sign-extended.
  - BU: same lane, zero-extended.
  - H: half addr[1], sign-extended.
  - HU: same half, zero-extended.
  - W: whole word.
- ACCESS → RESP on the edge where `mem_ack` = 1; extracted data is registered into `resp_rdata` at that edge.
- RESP → IDLE unconditionally after one cycle.
- `mem_ack` seen outside ACCESS is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 0 while `reset` is high, 1 on the first cycle after.
  - `resp_valid`, `resp_error`, `mem_req`, `mem_we` = 0.
  - `resp_rdata`, `mem_addr`, `mem_be`, `mem_wdata` = 0.
- Latency for a valid access with ack in its first ACCESS cycle:
  - Accepted at edge N: `mem_req` high in cycle N+1.
  - Ack at edge N+1: `resp_valid` high in cycle N+2.
- Each extra wait cycle adds one cycle of latency.
- Error response: `resp_valid` high in the cycle after acceptance.
- Throughput: one access per 3 cycles minimum. `req_ready` is low in ACCESS and RESP; `req_valid` there has no effect.
- `mem_req` drops in the cycle after the ack cycle; there is no back-to-back `mem_req`.
- Reset asserted in ACCESS or RESP:
  - Returns to IDLE at that edge.
  - `mem_req` and `resp_valid` are low in the next cycle.
  - No response is produced for the aborted access.
- `resp_rdata` and `resp_error` hold their values until the next response. Only `resp_valid` qualifies them.

## Test plan
- **LW, zero-wait ack**: `mem_rdata` = 0xDEADBEEF, LW at addr 0x0. Expect `mem_addr` = 0x0 and `mem_be` = 1111, then `resp_rdata` = 0xDEADBEEF with `resp_valid` exactly 2 cycles after acceptance.
- **Sub-word loads**: word = 0x80FF7F01.
  - LB @0x3 → 0xFFFFFF80.
  - LBU @0x3 → 0x00000080.
  - LH @0x2 → 0xFFFF80FF.
  - LHU @0x0 → 0x00007F01.
- **Stores**:
  - SH @0x6, wdata 0x1234ABCD → `mem_addr` 0x4, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `mem_we` 1.
  - SB @0x1, wdata 0x000000EF → `mem_be` 0010, `mem_wdata` 0xEFEFEFEF.
- **Errors**:
  - LW @0x2 → `resp_error` 1, `resp_rdata` 0, `resp_valid` 1 cycle after acceptance, `mem_req` never high.
  - funct3 = 100 with write → `resp_error` 1.
- **Wait states**: ack delayed 3 cycles → `mem_req`/`mem_addr`/`mem_be` held stable for 4 cycles, `resp_valid` the cycle after the ack, `req_ready` low throughout.
- **Reset mid-access**: `reset` pulsed in the 2nd ACCESS cycle → `mem_req` low next cycle, no `resp_valid`, `req_ready` = 1 the cycle after reset deasserts.
